// File: rtl/wb_queue.sv
// Write-back queue: accepts up to two register writes per cycle (mem stage first, ALU second),
// retires one per cycle onto the register file write port, and forwards the youngest pending
// value for two decode-stage read addresses.
module wb_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       stall,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic [ADDR_W-1:0]          look_addr1,
  input  logic [ADDR_W-1:0]          look_addr2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] StallThr = CntW'(DEPTH - 2);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              push_mem, push_alu, pop, drop;
  logic [PtrW-1:0]   mem_ptr, alu_ptr;

  // Pointer increment wrapping at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (int'(p) == int'(DEPTH) - 1) return '0;
    return p + PtrW'(1);
  endfunction

  // Pointer offset by i entries, modulo DEPTH.
  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int i);
    int sum;
    sum = int'(p) + i;
    if (sum >= int'(DEPTH)) sum = sum - int'(DEPTH);
    return PtrW'(sum);
  endfunction

  assign stall = (count_q > StallThr);

  // Push/pop decisions and next-state for pointers, count and overflow.
  always_comb begin
    push_mem   = mem_valid & ~stall;
    push_alu   = alu_valid & ~stall;
    drop       = (mem_valid | alu_valid) & stall;
    pop        = (count_q != '0);
    // mem is the older instruction, so it takes the tail slot first.
    mem_ptr    = tail_q;
    alu_ptr    = push_mem ? ptr_inc(tail_q) : tail_q;
    tail_d     = tail_q;
    if (push_alu)      tail_d = ptr_inc(alu_ptr);
    else if (push_mem) tail_d = ptr_inc(mem_ptr);
    head_d     = pop ? ptr_inc(head_q) : head_q;
    count_d    = count_q + CntW'(push_mem) + CntW'(push_alu) - CntW'(pop);
    overflow_d = overflow_q | drop;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; cleared on reset so the write port reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_mem) begin
        addr_q[mem_ptr] <= mem_addr;
        data_q[mem_ptr] <= mem_data;
      end
      if (push_alu) begin
        addr_q[alu_ptr] <= alu_addr;
        data_q[alu_ptr] <= alu_data;
      end
    end
  end

  // Write port is driven purely from stored state.
  assign rf_we    = (count_q != '0);
  assign rf_waddr = addr_q[head_q];
  assign rf_wdata = data_q[head_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  // Forwarding: walk occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i < int'(count_q)) begin
        if (addr_q[ptr_add(head_q, i)] == look_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[ptr_add(head_q, i)];
        end
        if (addr_q[ptr_add(head_q, i)] == look_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[ptr_add(head_q, i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Randomized and directed bench for wb_queue against a queue-based reference model.
module tb_wb_queue;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, mem_valid;
  logic [ADDR_W-1:0] alu_addr, mem_addr, look_addr1, look_addr2, rf_waddr;
  logic [DATA_W-1:0] alu_data, mem_data, rf_wdata, fwd_data1, fwd_data2;
  logic              stall, rf_we, fwd_hit1, fwd_hit2, overflow;
  logic [CntW-1:0]   count;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];
  logic m_ovf;
  int   checks = 0;
  int   errors = 0;

  wb_queue #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .stall     (stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .look_addr1(look_addr1),
    .look_addr2(look_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for an address; 0 on miss.
  task automatic fwd_model(input logic [ADDR_W-1:0] a, output logic hit,
                           output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (mq[i]) begin
      if (mq[i].a == a) begin
        hit = 1'b1;
        d   = mq[i].d;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic              h;
    logic [DATA_W-1:0] d;
    check({tag, ":rf_we"}, 32'(rf_we), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({tag, ":rf_waddr"}, 32'(rf_waddr), 32'(mq[0].a));
      check({tag, ":rf_wdata"}, 32'(rf_wdata), 32'(mq[0].d));
    end
    check({tag, ":count"}, 32'(count), 32'(mq.size()));
    check({tag, ":stall"}, 32'(stall), 32'(mq.size() > int'(DEPTH) - 2));
    check({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    fwd_model(look_addr1, h, d);
    check({tag, ":fwd_hit1"}, 32'(fwd_hit1), 32'(h));
    check({tag, ":fwd_data1"}, 32'(fwd_data1), 32'(d));
    fwd_model(look_addr2, h, d);
    check({tag, ":fwd_hit2"}, 32'(fwd_hit2), 32'(h));
    check({tag, ":fwd_data2"}, 32'(fwd_data2), 32'(d));
  endtask

  // Called at a falling edge: drive, check, advance the model across the rising edge.
  task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input logic [ADDR_W-1:0] la1, input logic [ADDR_W-1:0] la2,
                      input string tag);
    ent_t e;
    bit   full;
    alu_valid  = av;
    alu_addr   = aa;
    alu_data   = ad;
    mem_valid  = mv;
    mem_addr   = ma;
    mem_data   = md;
    look_addr1 = la1;
    look_addr2 = la2;
    #1 check_outputs(tag);
    @(posedge clk);
    full = (mq.size() > int'(DEPTH) - 2);
    if (mq.size() != 0) void'(mq.pop_front());
    if (full) begin
      if (av || mv) m_ovf = 1'b1;
    end else begin
      if (mv) begin
        e.a = ma;
        e.d = md;
        mq.push_back(e);
      end
      if (av) begin
        e.a = aa;
        e.d = ad;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] la1, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, la1, '0, tag);
  endtask

  initial begin
    m_ovf      = 1'b0;
    rst        = 1'b1;
    alu_valid  = 1'b0;
    mem_valid  = 1'b0;
    alu_addr   = '0;
    mem_addr   = '0;
    alu_data   = '0;
    mem_data   = '0;
    look_addr1 = '0;
    look_addr2 = '0;
    #2;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
    check("rst_fwd_data1", 32'(fwd_data1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1, '0, "idle0");

    // Single push
    step(1'b1, 3'd2, 16'h1234, 1'b0, '0, '0, 3'd2, '0, "single");
    check("single_rf_we", 32'(rf_we), 32'd1);
    check("single_rf_waddr", 32'(rf_waddr), 32'd2);
    check("single_rf_wdata", 32'(rf_wdata), 32'h1234);
    idle(1, 3'd2, "single_drain");
    check("single_count_after", 32'(count), 32'd0);

    // Dual push ordering: mem entry is older
    step(1'b1, 3'd5, 16'h00BB, 1'b1, 3'd5, 16'h00AA, 3'd5, '0, "dual");
    check("dual_first", 32'(rf_wdata), 32'h00AA);
    check("dual_fwd", 32'(fwd_data1), 32'h00BB);
    idle(1, 3'd5, "dual_r1");
    check("dual_second", 32'(rf_wdata), 32'h00BB);
    idle(2, 3'd7, "dual_r2");

    // Forwarding miss then hit
    check("fwd_miss_hit", 32'(fwd_hit1), 32'd0);
    check("fwd_miss_data", 32'(fwd_data1), 32'd0);
    step(1'b1, 3'd7, 16'hBEEF, 1'b0, '0, '0, 3'd7, '0, "fwd_push");
    check("fwd_hit", 32'(fwd_hit1), 32'd1);
    check("fwd_data", 32'(fwd_data1), 32'hBEEF);
    idle(2, 3'd7, "fwd_drain");

    // Fill to stall, then a dropped push
    step(1'b1, 3'd1, 16'h0002, 1'b1, 3'd0, 16'h0001, 3'd1, 3'd0, "fill1");
    step(1'b1, 3'd3, 16'h0004, 1'b1, 3'd1, 16'h0003, 3'd1, 3'd3, "fill2");
    check("fill_stall", 32'(stall), 32'd1);
    step(1'b1, 3'd4, 16'h0006, 1'b1, 3'd4, 16'h0005, 3'd4, 3'd1, "fill3");
    check("fill_overflow", 32'(overflow), 32'd1);
    idle(4, 3'd4, "fill_drain");

    // Single pushes across pointer wrap
    for (int i = 0; i < 10; i++)
      step(1'b1, ADDR_W'(i), 16'h0100 + 16'(i), 1'b0, '0, '0, ADDR_W'(i), ADDR_W'(i + 7), "wrap");
    idle(2, '0, "wrap_drain");

    // Async reset with three entries queued
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 3'd1, 3'd2, "pre_rst1");
    step(1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 16'h4444, 3'd1, 3'd2, "pre_rst2");
    check("pre_rst_count", 32'(count), 32'd3);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("mid_rst_rf_we", 32'(rf_we), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3, 3'd1, "post_rst");

    // Randomized traffic with varying load
    for (int i = 0; i < 400; i++) begin
      int rate;
      rate = 20 + 30 * ((i / 50) % 3);
      step($urandom_range(0, 99) < rate, ADDR_W'($urandom), DATA_W'($urandom),
           $urandom_range(0, 99) < rate, ADDR_W'($urandom), DATA_W'($urandom),
           ADDR_W'($urandom), ADDR_W'($urandom), "rand");
    end
    idle(5, '0, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
